out_port_fifo: RTL and testbench

OUT_PORT_FIFO -- requirements
Module: out_port_fifo

---
 rtl/out_port_pkg.sv | 15 +
 rtl/fifo_mem.sv | 27 ++
 rtl/out_port_fifo.sv | 106 ++++++++++
 tb/tb_out_port_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/out_port_pkg.sv
// rtl/out_port_pkg.sv - shared sizing constants and helpers for the output port FIFO
package out_port_pkg;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DROP_W = 8;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [DROP_W-1:0] sat_inc8(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH register file, one write port, one async read port
module fifo_mem #(
  parameter int WIDTH = out_port_pkg::WIDTH,
  parameter int DEPTH = out_port_pkg::DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Storage is deliberately left unreset; control logic masks stale words
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the accepted word into the slot addressed by the write pointer
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/out_port_fifo.sv
// rtl/out_port_fifo.sv - processor output FIFO with overflow tracking and drop counter
module out_port_fifo #(
  parameter int WIDTH = out_port_pkg::WIDTH,
  parameter int DEPTH = out_port_pkg::DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr_en,
  input  logic                     rd_ready,
  input  logic                     ovf_clr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  import out_port_pkg::sat_inc8;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic is_full;
  logic is_empty;
  logic do_pop;
  logic do_push;
  logic do_drop;

  // Decide pop/push/drop for this cycle and compute next-state values
  always_comb begin
    is_full  = (count_q == CNT_W'(DEPTH));
    is_empty = (count_q == '0);
    do_pop   = rd_ready && !is_empty;
    // A pop in the same cycle frees a slot, so a full queue still accepts
    do_push  = wr_en && (!is_full || do_pop);
    do_drop  = wr_en && !do_push;

    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (do_drop) begin
      // A drop wins over a concurrent clear: the clear happens, then this drop counts
      overflow_d   = 1'b1;
      drop_count_d = ovf_clr ? 8'd1 : sat_inc8(drop_count_q);
    end else if (ovf_clr) begin
      overflow_d   = 1'b0;
      drop_count_d = 8'd0;
    end
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clock   (clock),
    .wr_en   (do_push),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign rd_valid   = !is_empty;
  assign empty      = is_empty;
  assign full       = is_full;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_out_port_fifo.sv
// tb/tb_out_port_fifo.sv - self-checking bench for out_port_fifo against a queue model
module tb_out_port_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_ready;
  logic             ovf_clr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic [3:0]       count;
  logic             overflow;
  logic [7:0]       drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain queue plus overflow bookkeeping
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf = 1'b0;
  int               m_drop = 0;
  logic [WIDTH-1:0] pop_seen;
  bit               pop_happened;

  out_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .wr_en      (wr_en),
    .rd_ready   (rd_ready),
    .ovf_clr    (ovf_clr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive at negedge, advance model at posedge, return at next negedge
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
    bit m_pop, m_push, m_drp;
    wr_en = w; din = d; rd_ready = r; ovf_clr = c;
    m_pop  = r && (mq.size() > 0);
    m_push = w && ((mq.size() < DEPTH) || m_pop);
    m_drp  = w && !m_push;
    #1;
    pop_seen     = rd_data;
    pop_happened = m_pop;
    @(posedge clock);
    if (m_pop)  void'(mq.pop_front());
    if (m_push) mq.push_back(d);
    if (m_drp) begin
      m_ovf  = 1'b1;
      m_drop = c ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (c) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    @(negedge clock);
    wr_en = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic fill(input logic [WIDTH-1:0] base);
    for (int i = 0; i < DEPTH; i++) step(1'b1, base + WIDTH'(i), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (count !== 4'd0)      begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0)       begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (rd_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL post_reset_empty: got %b expected 1", empty); end
  endtask

  task automatic test_ordering();
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h0001) begin n_fail++; $display("FAIL order_latency: got valid=%b data=%h expected valid=1 data=0001", rd_valid, rd_data); end
    step(1'b1, 16'h0002, 1'b0, 1'b0);
    step(1'b1, 16'h0003, 1'b0, 1'b0);
    n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL order_count: got %0d expected 3", count); end
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (pop_seen !== WIDTH'(k)) begin n_fail++; $display("FAIL order_data: got %h expected %h", pop_seen, WIDTH'(k)); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL order_empty: got %b expected 1", empty); end
  endtask

  task automatic test_full_drop();
    for (int i = 0; i < 9; i++) step(1'b1, 16'h00A0 + WIDTH'(i), 1'b0, 1'b0);
    n_checks++; if (full !== 1'b1)       begin n_fail++; $display("FAIL drop_full: got %b expected 1", full); end
    n_checks++; if (count !== 4'd8)      begin n_fail++; $display("FAIL drop_count_occ: got %0d expected 8", count); end
    n_checks++; if (overflow !== 1'b1)   begin n_fail++; $display("FAIL drop_overflow: got %b expected 1", overflow); end
    n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL drop_drop_count: got %0d expected 1", drop_count); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (pop_seen !== 16'h00A0 + WIDTH'(i)) begin n_fail++; $display("FAIL drop_drain: got %h expected %h", pop_seen, 16'h00A0 + WIDTH'(i)); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drop_empty: got %b expected 1", empty); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL drop_clear: got ovf=%b cnt=%0d expected 0/0", overflow, drop_count); end
  endtask

  task automatic test_push_pop_full();
    fill(16'h0010);
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    n_checks++; if (pop_seen !== 16'h0010) begin n_fail++; $display("FAIL ppf_head: got %h expected 0010", pop_seen); end
    n_checks++; if (count !== 4'd8)        begin n_fail++; $display("FAIL ppf_count: got %0d expected 8", count); end
    n_checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL ppf_nodrop: got ovf=%b cnt=%0d expected 0/0", overflow, drop_count); end
    for (int i = 1; i <= DEPTH; i++) begin
      logic [WIDTH-1:0] exp_w;
      exp_w = (i == DEPTH) ? 16'h1234 : 16'h0010 + WIDTH'(i);
      step(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (pop_seen !== exp_w) begin n_fail++; $display("FAIL ppf_drain: got %h expected %h", pop_seen, exp_w); end
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] got[$];
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'h0100 + WIDTH'(i), 1'b1, 1'b0);
      if (pop_happened) got.push_back(pop_seen);
      n_checks++; if (count > 4'd1) begin n_fail++; $display("FAIL wrap_count: got %0d expected <=1", count); end
    end
    step(1'b0, '0, 1'b1, 1'b0);
    if (pop_happened) got.push_back(pop_seen);
    n_checks++; if (got.size() !== 20) begin n_fail++; $display("FAIL wrap_size: got %0d expected 20", got.size()); end
    for (int i = 0; i < got.size() && i < 20; i++) begin
      n_checks++; if (got[i] !== 16'h0100 + WIDTH'(i)) begin n_fail++; $display("FAIL wrap_data: got %h expected %h", got[i], 16'h0100 + WIDTH'(i)); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  task automatic test_drop_clear();
    fill(16'h0020);
    step(1'b1, 16'hDEAD, 1'b0, 1'b1);
    n_checks++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin n_fail++; $display("FAIL dc_same_cycle: got ovf=%b cnt=%0d expected 1/1", overflow, drop_count); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL dc_clear: got ovf=%b cnt=%0d expected 0/0", overflow, drop_count); end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL dc_count: got %0d expected 8", count); end
    drain();
  endtask

  task automatic test_saturation();
    fill(16'h0040);
    for (int i = 0; i < 260; i++) step(1'b1, 16'h5555, 1'b0, 1'b0);
    n_checks++; if (drop_count !== 8'd255 || overflow !== 1'b1) begin n_fail++; $display("FAIL sat_drop_count: got cnt=%0d ovf=%b expected 255/1", drop_count, overflow); end
    step(1'b0, '0, 1'b0, 1'b1);
    drain();
    n_checks++; if (drop_count !== 8'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL sat_cleanup: got cnt=%0d empty=%b expected 0/1", drop_count, empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0030 + WIDTH'(i), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (count !== 4'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got count=%0d empty=%b valid=%b expected 0/1/0", count, empty, rd_valid); end
    #14 reset = 1'b0;
    mq.delete();
    @(negedge clock);
    n_checks++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL rmid_after: got count=%0d empty=%b expected 0/1", count, empty); end
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF || count !== 4'd1) begin n_fail++; $display("FAIL rmid_head: got valid=%b data=%h count=%0d expected 1/beef/1", rd_valid, rd_data, count); end
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (pop_seen !== 16'hBEEF || empty !== 1'b1) begin n_fail++; $display("FAIL rmid_pop: got data=%h empty=%b expected beef/1", pop_seen, empty); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 60), WIDTH'($urandom), ($urandom_range(0, 99) < 45), ($urandom_range(0, 15) == 0));
      n_checks++; if (int'(count) !== mq.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", count, mq.size()); end
      n_checks++; if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) || rd_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_flags: got e=%b f=%b v=%b for size %0d", empty, full, rd_valid, mq.size()); end
      n_checks++; if (overflow !== m_ovf || int'(drop_count) !== m_drop) begin n_fail++; $display("FAIL rand_ovf: got ovf=%b cnt=%0d expected %b/%0d", overflow, drop_count, m_ovf, m_drop); end
      if (mq.size() > 0) begin
        n_checks++; if (rd_data !== mq[0]) begin n_fail++; $display("FAIL rand_head: got %h expected %h", rd_data, mq[0]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; din = '0; wr_en = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_ordering();
    test_full_drop();
    test_push_pop_full();
    test_wrap();
    test_drop_clear();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
